// File: rtl/hazard_scoreboard.sv
// Purpose: per-register latency scoreboard that detects RAW/WAW hazards for the ID instruction.
// Latency: hazard outputs are combinational from registered counters; counters update next edge.
// Backpressure: ext_stall freezes all counters and blocks issue; stall still reports hazards.
//
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   id_valid/id_rs/id_rt/... - ID-stage instruction (sources, destination, result latency)
//   ext_stall, flush         - downstream freeze, cancel the ID instruction
//   issue, stall, bubble     - issue to EX, hold IF/ID, insert NOP into EX
//   busy_vec                 - bit r set while register r has a pending result
module hazard_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int LW   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [AW-1:0]   id_rs,
  input  logic [AW-1:0]   id_rt,
  input  logic            id_rs_used,
  input  logic            id_rt_used,
  input  logic [AW-1:0]   id_rd,
  input  logic            id_wen,
  input  logic [LW-1:0]   id_lat,
  input  logic            ext_stall,
  input  logic            flush,
  output logic            issue,
  output logic            stall,
  output logic            bubble,
  output logic [NREG-1:0] busy_vec
);

  // Countdown per register; entry 0 is never written so it stays zero.
  logic [LW-1:0] cnt_q [NREG];
  logic [LW-1:0] cnt_d [NREG];

  logic [LW-1:0] rs_cnt;
  logic [LW-1:0] rt_cnt;
  logic [LW-1:0] rd_cnt;
  logic          raw;
  logic          waw;

  // Read the counters addressed by the ID instruction. Indices outside
  // 1..NREG-1 read as zero, so register 0 can never raise a hazard.
  always_comb begin
    rs_cnt = '0;
    rt_cnt = '0;
    rd_cnt = '0;
    for (int r = 1; r < NREG; r++) begin
      if (id_rs == AW'(r)) rs_cnt = cnt_q[r];
      if (id_rt == AW'(r)) rt_cnt = cnt_q[r];
      if (id_rd == AW'(r)) rd_cnt = cnt_q[r];
    end
  end

  assign raw = (id_rs_used && (id_rs != '0) && (rs_cnt != '0)) ||
               (id_rt_used && (id_rt != '0) && (rt_cnt != '0));

  // A new write may not complete before an older write to the same register.
  assign waw = id_wen && (id_rd != '0) && (rd_cnt > id_lat);

  assign stall  = id_valid && !flush && (raw || waw);
  assign issue  = id_valid && !flush && !stall && !ext_stall;
  assign bubble = stall && !ext_stall;

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
    end
    cnt_d[0] = '0;
    if (!ext_stall) begin
      for (int r = 1; r < NREG; r++) begin
        if (cnt_q[r] != '0) cnt_d[r] = cnt_q[r] - LW'(1);
        // A fresh load wins over the decrement of the same register.
        if (issue && id_wen && (id_lat != '0) && (id_rd == AW'(r))) cnt_d[r] = id_lat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    busy_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      busy_vec[r] = (cnt_q[r] != '0);
    end
  end

endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL take parameter NREG, default 32: number of architectural registers.
REQ-002 SHALL take parameter AW, default 5: register index width, with 2^AW >= NREG.
REQ-003 SHALL take parameter LW, default 3: latency counter width; maximum latency is 2^LW-1.
REQ-004 SHALL provide clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL provide rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL provide id_valid, input, 1: ID holds an instruction requesting issue.
REQ-007 SHALL provide id_rs / id_rt, inputs, AW each: source register indices.
REQ-008 SHALL provide id_rs_used / id_rt_used, inputs, 1 each: source actually read.
REQ-009 SHALL provide id_rd, input, AW: destination register index.
REQ-010 SHALL provide id_wen, input, 1: instruction writes id_rd.
REQ-011 SHALL provide id_lat, input, LW: cycles until result is forwardable (0 = ALU, 1 = load, >1 = mult/div).
REQ-012 SHALL provide ext_stall, input, 1: downstream (dcache) freeze.
REQ-013 SHALL provide flush, input, 1: cancel the ID instruction this cycle.
REQ-014 SHALL provide issue, output, 1: ID instruction issues to EX this cycle.
REQ-015 SHALL provide stall, output, 1: IF/ID must hold due to a scoreboard hazard.
REQ-016 SHALL provide bubble, output, 1: insert a NOP into EX this cycle.
REQ-017 SHALL provide busy_vec, output, NREG: bit r set when cnt[r] != 0.

Function
REQ-018 SHALL hold one LW-bit countdown cnt[r] per register r in 1..NREG-1.
REQ-019 SHALL tie cnt[0] to 0 permanently, so register 0 never raises a hazard.
REQ-020 SHALL set raw = (id_rs_used & id_rs!=0 & cnt[id_rs]!=0) | (same condition for rt).
REQ-021 SHALL set waw = id_wen & id_rd!=0 & cnt[id_rd] > id_lat, so that results complete in order.
REQ-022 SHALL set stall = id_valid & ~flush & (raw | waw), combinationally from registered cnt.
REQ-023 SHALL set issue = id_valid & ~flush & ~stall & ~ext_stall.
REQ-024 SHALL set bubble = stall & ~ext_stall.
REQ-025 SHALL, when ext_stall=1, freeze all cnt, issue nothing, and still report stall.
REQ-026 SHALL, per cycle with ext_stall=0, decrement every nonzero cnt by 1 and saturate at 0.
REQ-027 SHALL, on issue with id_wen=1, id_rd!=0 and id_lat>0, load cnt[id_rd] = id_lat; this load overrides the decrement of the same register in that cycle.
REQ-028 SHALL NOT change any cnt on issue with id_lat=0.
REQ-029 SHALL leave all counters untouched on flush; older in-flight writes still complete.
REQ-030 SHALL produce a load-use penalty of exactly 1 bubble (lat=1) and, for lat=L, L bubbles for an immediately dependent instruction.
REQ-031 SHALL have outputs depend only on registered cnt and current-cycle inputs, with no combinational path from any output back to inputs.

Reset
REQ-032 SHALL, while rst=1 at a clock edge, clear every cnt to 0.
REQ-033 SHALL have busy_vec=0 after reset, and stall=0, bubble=0 for any inputs; issue follows REQ-023.
REQ-034 SHALL, on rst asserted mid-operation, discard pending latencies; rst takes precedence over issue loads and decrements in the same cycle.

Verification
REQ-035 Load-use: issue lw rd=8, lat=1, then add rs=8 -> cycle 1: stall=1, bubble=1, busy_vec[8]=1; cycle 2: issue=1, busy_vec[8]=0.
REQ-036 Mult latency: issue rd=9, lat=4, then dependent rt=9 -> exactly 4 cycles of bubble=1, then issue=1.
REQ-037 WAW: issue rd=5, lat=4, then ALU rd=5, lat=0, no source hazard -> stall until cnt[5]=0 (4 bubbles); lat-4 op to rd=5 issued after 1 cycle has no WAW stall.
REQ-038 ext_stall: cnt[3]=2, ext_stall=1 for 3 cycles -> cnt[3] stays 2, issue=0, bubble=0; after release, 2 further cycles until busy_vec[3]=0.
REQ-039 Register 0 and flush: lw rd=0, lat=1 -> busy_vec=0; dependent on reg 0 issues with no stall; flush=1 with hazard present -> stall=0, issue=0, cnt unchanged.
REQ-040 Reset mid-op: cnt[7]=5, rst=1 one cycle -> busy_vec=0 next cycle; dependent on reg 7 issues immediately.
